prog_loader: RTL and testbench

//  Host-side loader that fills the processor's instruction (text) and data memories before execution.

---
 rtl/prog_loader.sv | 219 +++++++++++++++++++++
 tb/tb_prog_loader.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// prog_loader: byte-stream loader for text/data memories; holds cpu in reset.
// Optional per-record checksum when CHECKSUM_EN is defined.
//
// Ports:
//   clk, reset (sync, active-low)
//   in_data/in_valid/in_ready : byte stream handshake
//   mem_we/mem_seg/mem_addr/mem_wdata : memory write port
//   proc_reset : processor reset, load_done : loaded + released
//   load_err : sticky checksum error (tied 0 without CHECKSUM_EN)
module prog_loader #(
  parameter int ADDR_W      = 16,
  parameter int RELEASE_DLY = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              mem_we,
  output logic              mem_seg,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic              proc_reset,
  output logic              load_done,
  output logic              load_err
);

  localparam int DW = (RELEASE_DLY > 1) ? $clog2(RELEASE_DLY) : 1;

  typedef enum logic [2:0] {
    ST_HDR_HI,
    ST_HDR_LO,
    ST_ADDR_HI,
    ST_ADDR_LO,
    ST_DATA_HI,
    ST_DATA_LO,
    ST_RELEASE
`ifdef CHECKSUM_EN
    , ST_CHK
`endif
  } state_t;

  state_t state_q, state_d;

  logic [14:0]       cnt_q, cnt_d;
  logic [7:0]        hi_q, hi_d;
  logic              seg_q, seg_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DW-1:0]     dly_q, dly_d;

  logic              in_ready_q, in_ready_d;
  logic              mem_we_q, mem_we_d;
  logic              mem_seg_q, mem_seg_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [15:0]       mem_wdata_q, mem_wdata_d;
  logic              proc_reset_q, proc_reset_d;
  logic              load_done_q, load_done_d;

  logic              xfer;
  logic              err_now;
  state_t            after_data;

`ifdef CHECKSUM_EN
  logic [7:0] sum_q, sum_d;
  logic [7:0] chk_sum;
  logic       err_q, err_d;

  assign chk_sum    = sum_q + in_data;
  assign err_now    = err_q;
  assign after_data = ST_CHK;
`else
  assign err_now    = 1'b0;
  assign after_data = ST_HDR_HI;
`endif

  assign xfer = in_valid && in_ready_q;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    hi_d         = hi_q;
    seg_d        = seg_q;
    addr_d       = addr_q;
    dly_d        = dly_q;
    mem_we_d     = 1'b0;
    mem_seg_d    = mem_seg_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    proc_reset_d = proc_reset_q;
    load_done_d  = load_done_q;
`ifdef CHECKSUM_EN
    sum_d        = sum_q;
    err_d        = err_q;
`endif
    unique case (state_q)
      ST_HDR_HI: if (xfer) begin
        seg_d   = in_data[7];
        cnt_d   = {in_data[6:0], cnt_q[7:0]};
        state_d = ST_HDR_LO;
`ifdef CHECKSUM_EN
        sum_d   = 8'h00;
`endif
        // any header after release starts a reload
        if (load_done_q) begin
          proc_reset_d = 1'b1;
          load_done_d  = 1'b0;
        end
      end
      ST_HDR_LO: if (xfer) begin
        cnt_d = {cnt_q[14:8], in_data};
        if ({cnt_q[14:8], in_data} == 15'd0) begin
          state_d = ST_RELEASE;
          dly_d   = DW'(RELEASE_DLY - 1);
        end else begin
          state_d = ST_ADDR_HI;
        end
      end
      ST_ADDR_HI: if (xfer) begin
        hi_d    = in_data;
        state_d = ST_ADDR_LO;
      end
      ST_ADDR_LO: if (xfer) begin
        addr_d  = ADDR_W'({hi_q, in_data});
        state_d = ST_DATA_HI;
      end
      ST_DATA_HI: if (xfer) begin
        hi_d    = in_data;
        state_d = ST_DATA_LO;
`ifdef CHECKSUM_EN
        sum_d   = chk_sum;
`endif
      end
      ST_DATA_LO: if (xfer) begin
        mem_we_d    = 1'b1;
        mem_seg_d   = seg_q;
        mem_addr_d  = addr_q;
        mem_wdata_d = {hi_q, in_data};
        addr_d      = addr_q + ADDR_W'(1);
        cnt_d       = cnt_q - 15'd1;
        state_d     = (cnt_q == 15'd1) ? after_data : ST_DATA_HI;
`ifdef CHECKSUM_EN
        sum_d       = chk_sum;
`endif
      end
`ifdef CHECKSUM_EN
      ST_CHK: if (xfer) begin
        if (chk_sum != 8'h00) err_d = 1'b1;
        state_d = ST_HDR_HI;
      end
`endif
      ST_RELEASE: begin
        if (dly_q == '0) begin
          state_d      = ST_HDR_HI;
          proc_reset_d = err_now;
          load_done_d  = 1'b1;
        end else begin
          dly_d = dly_q - DW'(1);
        end
      end
      default: state_d = ST_HDR_HI;
    endcase
  end

  assign in_ready_d = (state_d != ST_RELEASE);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= ST_HDR_HI;
      cnt_q        <= '0;
      hi_q         <= '0;
      seg_q        <= 1'b0;
      addr_q       <= '0;
      dly_q        <= '0;
      in_ready_q   <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_seg_q    <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      proc_reset_q <= 1'b1;
      load_done_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      hi_q         <= hi_d;
      seg_q        <= seg_d;
      addr_q       <= addr_d;
      dly_q        <= dly_d;
      in_ready_q   <= in_ready_d;
      mem_we_q     <= mem_we_d;
      mem_seg_q    <= mem_seg_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      proc_reset_q <= proc_reset_d;
      load_done_q  <= load_done_d;
    end
  end

`ifdef CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      sum_q <= '0;
      err_q <= 1'b0;
    end else begin
      sum_q <= sum_d;
      err_q <= err_d;
    end
  end
`endif

  assign in_ready   = in_ready_q;
  assign mem_we     = mem_we_q;
  assign mem_seg    = mem_seg_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign proc_reset = proc_reset_q;
  assign load_done  = load_done_q;
  assign load_err   = err_now;

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: directed + randomized bench for prog_loader.
// Expected writes come from a record-level model of the byte stream.
`timescale 1ns/1ps
module tb_prog_loader;
  localparam int ADDR_W      = 16;
  localparam int RELEASE_DLY = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              mem_we;
  logic              mem_seg;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_wdata;
  logic              proc_reset;
  logic              load_done;
  logic              load_err;

  prog_loader #(
    .ADDR_W(ADDR_W),
    .RELEASE_DLY(RELEASE_DLY)
  ) dut (
    .clk(clk),
    .reset(reset),
    .in_data(in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .mem_we(mem_we),
    .mem_seg(mem_seg),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .proc_reset(proc_reset),
    .load_done(load_done),
    .load_err(load_err)
  );

  always #5 clk = ~clk;

  int checks  = 0;
  int errors  = 0;
  int gap_pct = 0;

  logic [32:0] got_q[$];
  logic [32:0] exp_q[$];
  logic [15:0] wq[$];

  always @(negedge clk)
    if (mem_we) got_q.push_back({mem_seg, mem_addr, mem_wdata});

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // returns #1 after the edge where the byte was accepted
  task automatic send(input logic [7:0] b);
    int cyc;
    while (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
      in_valid = 1'b0;
      tick();
    end
    in_data  = b;
    in_valid = 1'b1;
    cyc = 0;
    while (!in_ready && cyc < 64) begin
      tick();
      cyc++;
    end
    if (!in_ready) begin
      chk("in_ready_wait", {63'd0, in_ready}, 64'd1);
      return;
    end
    tick();
  endtask

  // model: record of wq words from addr, word address wraps at 2^16
  task automatic send_record(input logic seg, input int addr);
    int n;
`ifdef CHECKSUM_EN
    int sum;
    sum = 0;
`endif
    n = wq.size();
    send({seg, 7'(n >> 8)});
    send(8'(n));
    send(8'(addr >> 8));
    send(8'(addr));
    foreach (wq[i]) begin
      send(wq[i][15:8]);
      send(wq[i][7:0]);
      exp_q.push_back({seg, 16'((addr + i) % 65536), wq[i]});
`ifdef CHECKSUM_EN
      sum += int'(wq[i][15:8]) + int'(wq[i][7:0]);
`endif
    end
`ifdef CHECKSUM_EN
    send(8'((256 - (sum % 256)) % 256));
`endif
  endtask

  task automatic compare_writes(input string tag);
    chk({tag, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      chk($sformatf("%s_w%0d", tag, i), 64'(got_q[i]), 64'(exp_q[i]));
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic end_load(input string tag);
    int n;
    send(8'h00);
    send(8'h00);
    in_valid = 1'b0;
    n = 0;
    while (proc_reset && n < 50) begin
      tick();
      n++;
    end
    chk({tag, "_rel_dly"}, 64'(n), 64'(RELEASE_DLY));
    chk({tag, "_done"}, {63'd0, load_done}, 64'd1);
    chk({tag, "_ready"}, {63'd0, in_ready}, 64'd1);
    tick();
    compare_writes(tag);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nrec;
    int addr;
    reset    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;

    // 1: reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
    chk("rst_mem_we", {63'd0, mem_we}, 64'd0);
    chk("rst_proc_reset", {63'd0, proc_reset}, 64'd1);
    chk("rst_load_done", {63'd0, load_done}, 64'd0);
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    chk("rst_mem_wdata", 64'(mem_wdata), 64'd0);
    chk("rst_load_err", {63'd0, load_err}, 64'd0);
    reset = 1'b1;
    tick();
    chk("rel_in_ready", {63'd0, in_ready}, 64'd1);

    // 2: basic text record
    wq = {16'h1234, 16'hABCD};
    send_record(1'b0, 16'h0010);
    end_load("t2");

    // 3: data record wrapping at top of address space, reload flags
    send(8'h80);
    chk("reload_proc_reset", {63'd0, proc_reset}, 64'd1);
    chk("reload_load_done", {63'd0, load_done}, 64'd0);
    send(8'h02);
    send(8'hFF);
    send(8'hFF);
    send(8'h00);
    send(8'h01);
    send(8'h00);
    send(8'h02);
`ifdef CHECKSUM_EN
    send(8'hFD);
`endif
    exp_q.push_back({1'b1, 16'hFFFF, 16'h0001});
    exp_q.push_back({1'b1, 16'h0000, 16'h0002});
    end_load("t3");

    // 4: test 2 with random bubbles
    gap_pct = 40;
    wq = {16'h1234, 16'hABCD};
    send_record(1'b0, 16'h0010);
    end_load("t4");
    gap_pct = 0;

    // 5: reset after DATA_HI drops the partial word
    send(8'h00);
    send(8'h01);
    send(8'h00);
    send(8'h20);
    send(8'h12);
    in_valid = 1'b0;
    reset    = 1'b0;
    tick();
    chk("t5_mem_we", {63'd0, mem_we}, 64'd0);
    chk("t5_in_ready", {63'd0, in_ready}, 64'd0);
    chk("t5_proc_reset", {63'd0, proc_reset}, 64'd1);
    chk("t5_load_done", {63'd0, load_done}, 64'd0);
    chk("t5_mem_addr", 64'(mem_addr), 64'd0);
    reset = 1'b1;
    tick();
    chk("t5_partial", 64'(got_q.size()), 64'd0);
    wq = {16'h5A5A};
    send_record(1'b1, 16'h0300);
    end_load("t5");

    // randomized loads against the record model
    for (int l = 0; l < 4; l++) begin
      gap_pct = $urandom_range(0, 50);
      nrec = $urandom_range(1, 3);
      for (int r = 0; r < nrec; r++) begin
        wq.delete();
        for (int k = 0; k < $urandom_range(1, 5); k++)
          wq.push_back(16'($urandom));
        if ($urandom_range(0, 2) == 0)
          addr = 65535 - $urandom_range(0, 2);
        else
          addr = $urandom_range(0, 65535);
        send_record(1'($urandom_range(0, 1)), addr);
      end
      end_load($sformatf("rnd%0d", l));
    end
    gap_pct = 0;

`ifdef CHECKSUM_EN
    // 6: bad checksum
    send(8'h00);
    send(8'h02);
    send(8'h00);
    send(8'h10);
    send(8'h12);
    send(8'h34);
    send(8'hAB);
    send(8'hCD);
    send(8'h00);
    exp_q.push_back({1'b0, 16'h0010, 16'h1234});
    exp_q.push_back({1'b0, 16'h0011, 16'hABCD});
    chk("t6_err", {63'd0, load_err}, 64'd1);
    send(8'h00);
    send(8'h00);
    in_valid = 1'b0;
    repeat (RELEASE_DLY + 2) tick();
    chk("t6_proc_reset", {63'd0, proc_reset}, 64'd1);
    chk("t6_load_done", {63'd0, load_done}, 64'd1);
    chk("t6_err_sticky", {63'd0, load_err}, 64'd1);
    compare_writes("t6");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
